univ_counter_reg: RTL and testbench

- Parametrised universal counter register and next generation of the 8-bit universal counter-cell chain.
- Registers the count internally instead of taking the flip-flop state as an input.
- Adds a programmable modulus, a saturate-or-wrap option, a terminal-count output for cascading, and a sticky overflow flag.
- Used as the building block for timers and BCD/modulo counter chains in the counters/registers datapath.

---
 rtl/univ_counter_reg.sv | 97 +++++++++
 tb/tb_univ_counter_reg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/univ_counter_reg.sv
// Universal counter register: hold / load / up / down with programmable modulus,
// wrap-or-saturate at range ends, cascadable terminal count and sticky overflow.
module univ_counter_reg #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 2**WIDTH,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cin,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pin,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic [1:0]       mout,
    output logic             ovf
);

    localparam int unsigned XW = WIDTH + 1;
    localparam logic [XW-1:0] MOD_X = XW'(MODULUS);
    localparam logic [XW-1:0] TOP_X = XW'(MODULUS - 1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;

    logic [XW-1:0]    w_q_x;
    logic [XW-1:0]    w_pin_x;
    logic [XW-1:0]    w_next_x;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_set_ovf;

    // Next-state is formed one bit wider than the count, then truncated.
    always_comb begin
        w_q_x     = {1'b0, r_q};
        w_pin_x   = {1'b0, pin};
        w_at_top  = (w_q_x == TOP_X);
        w_at_zero = (r_q == '0);
        w_next_x  = w_q_x;
        w_set_ovf = 1'b0;
        case (mode)
            MODE_LOAD: begin
                if (w_pin_x >= MOD_X) begin
                    w_next_x  = TOP_X;
                    w_set_ovf = 1'b1;
                end else begin
                    w_next_x  = w_pin_x;
                end
            end
            MODE_UP: begin
                if (cin) begin
                    if (w_at_top) begin
                        w_set_ovf = 1'b1;
                        w_next_x  = SATURATE ? w_q_x : '0;
                    end else begin
                        w_next_x  = w_q_x + XW'(1);
                    end
                end
            end
            MODE_DOWN: begin
                if (cin) begin
                    if (w_at_zero) begin
                        w_set_ovf = 1'b1;
                        w_next_x  = SATURATE ? w_q_x : TOP_X;
                    end else begin
                        w_next_x  = w_q_x - XW'(1);
                    end
                end
            end
            MODE_HOLD: ;
            default:   ;
        endcase
    end

    // A set event in the same cycle as ovf_clr keeps the flag high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_next_x[WIDTH-1:0];
            r_ovf <= w_set_ovf | (r_ovf & ~ovf_clr);
        end
    end

    assign q    = r_q;
    assign ovf  = r_ovf;
    assign mout = mode;
    assign cout = cin & (((mode == MODE_UP) & w_at_top) | ((mode == MODE_DOWN) & w_at_zero));

endmodule

// File: tb/tb_univ_counter_reg.sv
// Bench for univ_counter_reg: directed scenarios plus random traffic against an
// integer-arithmetic model (wrap, saturate, full-width and a two-digit BCD chain).
module tb_univ_counter_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cin, ovf_clr;
    logic [1:0] mode;
    logic [7:0] pin;
    logic       c_cin;
    logic [1:0] c_mode;
    logic [3:0] c_plo, c_phi;

    logic [3:0] q_w, q_s, q_lo, q_hi;
    logic [7:0] q_f;
    logic       cout_w, cout_s, cout_f, cout_lo, cout_hi;
    logic [1:0] mout_w, mout_s, mout_f, mout_lo, mout_hi;
    logic       ovf_w, ovf_s, ovf_f, ovf_lo, ovf_hi;

    univ_counter_reg #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .cin(cin), .mode(mode), .pin(pin[3:0]),
        .ovf_clr(ovf_clr), .q(q_w), .cout(cout_w), .mout(mout_w), .ovf(ovf_w));

    univ_counter_reg #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .cin(cin), .mode(mode), .pin(pin[3:0]),
        .ovf_clr(ovf_clr), .q(q_s), .cout(cout_s), .mout(mout_s), .ovf(ovf_s));

    univ_counter_reg u_full (
        .clk(clk), .rst_n(rst_n), .cin(cin), .mode(mode), .pin(pin),
        .ovf_clr(ovf_clr), .q(q_f), .cout(cout_f), .mout(mout_f), .ovf(ovf_f));

    univ_counter_reg #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .rst_n(rst_n), .cin(c_cin), .mode(c_mode), .pin(c_plo),
        .ovf_clr(ovf_clr), .q(q_lo), .cout(cout_lo), .mout(mout_lo), .ovf(ovf_lo));

    univ_counter_reg #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .rst_n(rst_n), .cin(cout_lo), .mode(mout_lo), .pin(c_phi),
        .ovf_clr(ovf_clr), .q(q_hi), .cout(cout_hi), .mout(mout_hi), .ovf(ovf_hi));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: plain integers; the chain is a single decimal value 0..99.
    int m_w = 0, m_s = 0, m_f = 0, m_v = 0;
    bit o_w = 0, o_s = 0, o_f = 0, o_lo = 0, o_hi = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic bit exp_cout(input int modulus, input int qv);
        return cin && ((mode == 2'b10 && qv == modulus - 1) || (mode == 2'b11 && qv == 0));
    endfunction

    task automatic ref_step(input int modulus, input bit sat, input int pv,
                            input int q_i, input bit ov_i, output int q_o, output bit ov_o);
        bit ev = 1'b0;
        q_o = q_i;
        if (!rst_n) begin
            q_o = 0; ov_o = 1'b0;
            return;
        end
        case (mode)
            2'b01: begin
                ev  = (pv >= modulus);
                q_o = ev ? modulus - 1 : pv;
            end
            2'b10: if (cin) begin
                ev  = (q_i + 1 >= modulus);
                q_o = (ev && sat) ? q_i : (q_i + 1) % modulus;
            end
            2'b11: if (cin) begin
                ev  = (q_i == 0);
                q_o = (ev && sat) ? q_i : (q_i + modulus - 1) % modulus;
            end
            default: ;
        endcase
        ov_o = ev || (ov_i && !ovf_clr);
    endtask

    task automatic casc_step();
        int lo = m_v % 10, hi = m_v / 10;
        bit ev_lo = 1'b0, ev_hi = 1'b0;
        if (!rst_n) begin
            m_v = 0; o_lo = 1'b0; o_hi = 1'b0;
            return;
        end
        case (c_mode)
            2'b01: begin
                ev_lo = (c_plo > 9); ev_hi = (c_phi > 9);
                lo = ev_lo ? 9 : int'(c_plo);
                hi = ev_hi ? 9 : int'(c_phi);
                m_v = hi * 10 + lo;
            end
            2'b10: if (c_cin) begin
                ev_lo = (lo == 9); ev_hi = (m_v == 99);
                m_v = (m_v + 1) % 100;
            end
            2'b11: if (c_cin) begin
                ev_lo = (lo == 0); ev_hi = (m_v == 0);
                m_v = (m_v + 99) % 100;
            end
            default: ;
        endcase
        o_lo = ev_lo || (o_lo && !ovf_clr);
        o_hi = ev_hi || (o_hi && !ovf_clr);
    endtask

    // Combinational outputs checked mid-cycle, registered outputs just after the edge.
    task automatic tick();
        int nq;
        bit no;
        @(negedge clk);
        chk("cout_w", 32'(cout_w), 32'(exp_cout(10, m_w)));
        chk("cout_s", 32'(cout_s), 32'(exp_cout(10, m_s)));
        chk("cout_f", 32'(cout_f), 32'(exp_cout(256, m_f)));
        chk("mout_w", 32'(mout_w), 32'(mode));
        chk("mout_s", 32'(mout_s), 32'(mode));
        chk("mout_f", 32'(mout_f), 32'(mode));
        chk("mout_hi", 32'(mout_hi), 32'(c_mode));
        chk("cout_lo", 32'(cout_lo), 32'(c_cin && ((c_mode == 2'b10 && m_v % 10 == 9) ||
                                                    (c_mode == 2'b11 && m_v % 10 == 0))));
        chk("cout_hi", 32'(cout_hi), 32'(c_cin && ((c_mode == 2'b10 && m_v == 99) ||
                                                    (c_mode == 2'b11 && m_v == 0))));
        @(posedge clk);
        ref_step(10, 1'b0, int'(pin[3:0]), m_w, o_w, nq, no); m_w = nq; o_w = no;
        ref_step(10, 1'b1, int'(pin[3:0]), m_s, o_s, nq, no); m_s = nq; o_s = no;
        ref_step(256, 1'b0, int'(pin), m_f, o_f, nq, no);    m_f = nq; o_f = no;
        casc_step();
        #1;
        chk("q_w", 32'(q_w), 32'(m_w));     chk("ovf_w", 32'(ovf_w), 32'(o_w));
        chk("q_s", 32'(q_s), 32'(m_s));     chk("ovf_s", 32'(ovf_s), 32'(o_s));
        chk("q_f", 32'(q_f), 32'(m_f));     chk("ovf_f", 32'(ovf_f), 32'(o_f));
        chk("q_lo", 32'(q_lo), 32'(m_v % 10)); chk("ovf_lo", 32'(ovf_lo), 32'(o_lo));
        chk("q_hi", 32'(q_hi), 32'(m_v / 10)); chk("ovf_hi", 32'(ovf_hi), 32'(o_hi));
    endtask

    task automatic drive(input logic [1:0] md, input logic en, input logic [7:0] pv, input logic clr);
        mode = md; cin = en; pin = pv; ovf_clr = clr;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; cin = 1'b0; ovf_clr = 1'b0; mode = 2'b00; pin = '0;
        c_cin = 1'b0; c_mode = 2'b00; c_plo = '0; c_phi = '0;

        tick();
        chk("rst_q", 32'(q_w), 32'd0);
        chk("rst_ovf", 32'(ovf_w), 32'd0);
        rst_n = 1'b1;

        drive(2'b01, 1'b0, 8'd7, 1'b0);
        chk("load7", 32'(q_w), 32'd7);
        drive(2'b01, 1'b0, 8'd12, 1'b0);
        chk("load12_q", 32'(q_w), 32'd9);
        chk("load12_ovf", 32'(ovf_w), 32'd1);

        drive(2'b01, 1'b0, 8'd8, 1'b0);
        drive(2'b00, 1'b1, 8'd0, 1'b1);
        drive(2'b10, 1'b1, 8'd0, 1'b0); chk("up_9", 32'(q_w), 32'd9);
        drive(2'b10, 1'b1, 8'd0, 1'b0); chk("up_0", 32'(q_w), 32'd0);
        chk("up_wrap_ovf", 32'(ovf_w), 32'd1);
        chk("up_sat_hold", 32'(q_s), 32'd9);
        drive(2'b10, 1'b1, 8'd0, 1'b0); chk("up_1", 32'(q_w), 32'd1);
        drive(2'b00, 1'b0, 8'd0, 1'b1); chk("ovf_cleared", 32'(ovf_w), 32'd0);

        drive(2'b01, 1'b0, 8'd1, 1'b0);
        drive(2'b00, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) drive(2'b11, 1'b1, 8'd0, 1'b0);
        chk("dn_sat_q", 32'(q_s), 32'd0);
        chk("dn_sat_ovf", 32'(ovf_s), 32'd1);
        chk("dn_sat_cout", 32'(cout_s), 32'd1);

        drive(2'b01, 1'b0, 8'd4, 1'b0);
        for (int i = 0; i < 5; i++) drive(2'b10, 1'b0, 8'd0, 1'b0);
        drive(2'b00, 1'b1, 8'd0, 1'b0);
        chk("gated_hold", 32'(q_w), 32'd4);

        drive(2'b01, 1'b0, 8'd255, 1'b1);
        drive(2'b10, 1'b1, 8'd0, 1'b0);
        chk("full_wrap_q", 32'(q_f), 32'd0);
        chk("full_wrap_ovf", 32'(ovf_f), 32'd1);

        drive(2'b01, 1'b0, 8'd5, 1'b0);
        drive(2'b10, 1'b1, 8'd0, 1'b0);
        chk("mid_q6", 32'(q_w), 32'd6);
        rst_n = 1'b0;
        drive(2'b10, 1'b1, 8'd0, 1'b0);
        chk("mid_rst", 32'(q_w), 32'd0);
        rst_n = 1'b1;

        drive(2'b01, 1'b0, 8'd9, 1'b0);
        drive(2'b10, 1'b1, 8'd0, 1'b1);
        chk("race_ovf", 32'(ovf_w), 32'd1);
        drive(2'b00, 1'b0, 8'd0, 1'b0);

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        c_mode = 2'b10; c_cin = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        chk("bcd_hi", 32'(q_hi), 32'd2);
        chk("bcd_lo", 32'(q_lo), 32'd5);

        for (int i = 0; i < 400; i++) begin
            rst_n   = ($urandom_range(0, 31) != 0);
            mode    = 2'($urandom_range(0, 3));
            cin     = 1'($urandom_range(0, 1));
            pin     = 8'($urandom_range(0, 255));
            ovf_clr = ($urandom_range(0, 7) == 0);
            c_mode  = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            c_cin   = ($urandom_range(0, 3) != 0);
            c_plo   = 4'($urandom_range(0, 15));
            c_phi   = 4'($urandom_range(0, 15));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
